// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side inputs, forwarding sources and the execute-side outputs.
// The master modport is the pipeline/decode side and the slave modport is the stage itself.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  // Pipeline control
  logic              stall;
  logic              flush;

  // Decode slot
  logic              id_valid;
  logic [3:0]        id_alu_ctrl;
  logic              id_sign;
  logic              id_alu_src1;
  logic              id_alu_src2;
  logic              id_ext_op;
  logic [3:0]        id_ctrl;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [REG_AW-1:0] id_dst;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [15:0]       id_imm;
  logic [4:0]        id_shamt;

  // Writeback sources for forwarding
  logic              exm_regwrite;
  logic [REG_AW-1:0] exm_dst;
  logic [DATA_W-1:0] exm_data;
  logic              mwb_regwrite;
  logic [REG_AW-1:0] mwb_dst;
  logic [DATA_W-1:0] mwb_data;

  // Execute-side outputs
  logic [3:0]        alu_ctrl;
  logic              alu_sign;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_dst;
  logic [3:0]        ex_ctrl;
  logic              ex_valid;
  logic              load_use;

  modport master (
    output stall, flush,
    output id_valid, id_alu_ctrl, id_sign, id_alu_src1, id_alu_src2, id_ext_op, id_ctrl,
    output id_rs_addr, id_rt_addr, id_dst, id_rs_data, id_rt_data, id_imm, id_shamt,
    output exm_regwrite, exm_dst, exm_data, mwb_regwrite, mwb_dst, mwb_data,
    input  alu_ctrl, alu_sign, alu_in1, alu_in2, ex_store_data, ex_dst, ex_ctrl, ex_valid,
    input  load_use
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_alu_ctrl, id_sign, id_alu_src1, id_alu_src2, id_ext_op, id_ctrl,
    input  id_rs_addr, id_rt_addr, id_dst, id_rs_data, id_rt_data, id_imm, id_shamt,
    input  exm_regwrite, exm_dst, exm_data, mwb_regwrite, mwb_dst, mwb_data,
    output alu_ctrl, alu_sign, alu_in1, alu_in2, ex_store_data, ex_dst, ex_ctrl, ex_valid,
    output load_use
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and ALU operand selection.
// Optional feature macro: ID_EX_FORWARD_EN.
//   defined   - EX/MEM and MEM/WB results are forwarded into rs/rt; load_use flags only
//               loads sitting in EX.
//   undefined - no forwarding; load_use widens to a full RAW flag against EX and EX/MEM.
// ex_ctrl bit order: {RegWrite, MemRead, MemWrite, MemtoReg}.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  localparam int unsigned CtrlRegWrite = 3;
  localparam int unsigned CtrlMemRead  = 2;

  logic              r_valid;
  logic [3:0]        r_ctrl;
  logic [3:0]        r_alu_ctrl;
  logic              r_sign;
  logic              r_src1;
  logic              r_src2;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [REG_AW-1:0] r_dst;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_ext_imm;
  logic [4:0]        r_shamt;

  logic [DATA_W-1:0] w_ext_imm;
  logic [DATA_W-1:0] w_rs_fwd;
  logic [DATA_W-1:0] w_rt_fwd;
  logic              w_ex_match;

  // Extend the immediate before capture so EX only muxes.
  always_comb begin
    w_ext_imm = {{(DATA_W-16){1'b0}}, bus.id_imm};
    if (bus.id_ext_op) begin
      w_ext_imm = {{(DATA_W-16){bus.id_imm[15]}}, bus.id_imm};
    end
  end

  // Pipeline register: flush loads a bubble (all zero, opcode ADD), stall holds, else capture.
  // Bubble clears the source addresses too so a bubble never picks up forwarded data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_alu_ctrl <= '0;
      r_sign     <= 1'b0;
      r_src1     <= 1'b0;
      r_src2     <= 1'b0;
      r_rs_addr  <= '0;
      r_rt_addr  <= '0;
      r_dst      <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_ext_imm  <= '0;
      r_shamt    <= '0;
    end else if (bus.flush) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_alu_ctrl <= '0;
      r_sign     <= 1'b0;
      r_src1     <= 1'b0;
      r_src2     <= 1'b0;
      r_rs_addr  <= '0;
      r_rt_addr  <= '0;
      r_dst      <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_ext_imm  <= '0;
      r_shamt    <= '0;
    end else if (!bus.stall) begin
      r_valid    <= bus.id_valid;
      r_ctrl     <= bus.id_ctrl;
      r_alu_ctrl <= bus.id_alu_ctrl;
      r_sign     <= bus.id_sign;
      r_src1     <= bus.id_alu_src1;
      r_src2     <= bus.id_alu_src2;
      r_rs_addr  <= bus.id_rs_addr;
      r_rt_addr  <= bus.id_rt_addr;
      r_dst      <= bus.id_dst;
      r_rs_data  <= bus.id_rs_data;
      r_rt_data  <= bus.id_rt_data;
      r_ext_imm  <= w_ext_imm;
      r_shamt    <= bus.id_shamt;
    end
  end

  // EX holds an instruction whose destination is a non-zero source of the ID instruction.
  always_comb begin
    w_ex_match = (r_dst != '0) && ((r_dst == bus.id_rs_addr) || (r_dst == bus.id_rt_addr));
  end

`ifdef ID_EX_FORWARD_EN
  // Pick the youngest writer of a source register; $0 is never forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                                input logic [DATA_W-1:0] reg_data,
                                                input logic              exm_we,
                                                input logic [REG_AW-1:0] exm_dst,
                                                input logic [DATA_W-1:0] exm_data,
                                                input logic              mwb_we,
                                                input logic [REG_AW-1:0] mwb_dst,
                                                input logic [DATA_W-1:0] mwb_data);
    logic [DATA_W-1:0] sel;
    sel = reg_data;
    if (src != '0 && exm_we && exm_dst == src) begin
      sel = exm_data;
    end else if (src != '0 && mwb_we && mwb_dst == src) begin
      sel = mwb_data;
    end
    return sel;
  endfunction

  // Forwarded rs/rt operands, EX/MEM ahead of MEM/WB.
  always_comb begin
    w_rs_fwd = fwd_sel(r_rs_addr, r_rs_data, bus.exm_regwrite, bus.exm_dst, bus.exm_data,
                       bus.mwb_regwrite, bus.mwb_dst, bus.mwb_data);
    w_rt_fwd = fwd_sel(r_rt_addr, r_rt_data, bus.exm_regwrite, bus.exm_dst, bus.exm_data,
                       bus.mwb_regwrite, bus.mwb_dst, bus.mwb_data);
  end

  // Only a load in EX cannot be covered by forwarding.
  always_comb begin
    bus.load_use = r_valid && r_ctrl[CtrlMemRead] && w_ex_match;
  end
`else
  logic w_unused_fwd;
  logic w_exm_match;

  // Without forwarding, operands are the captured register file data.
  always_comb begin
    w_rs_fwd     = r_rs_data;
    w_rt_fwd     = r_rt_data;
    w_unused_fwd = ^{bus.exm_data, bus.mwb_regwrite, bus.mwb_dst, bus.mwb_data, r_rs_addr,
                     r_rt_addr};
  end

  // Any pending write in EX or EX/MEM to an ID source is a hazard; decode stalls on it.
  always_comb begin
    w_exm_match  = bus.exm_regwrite && (bus.exm_dst != '0) &&
                   ((bus.exm_dst == bus.id_rs_addr) || (bus.exm_dst == bus.id_rt_addr));
    bus.load_use = (r_valid && (r_ctrl[CtrlRegWrite] || r_ctrl[CtrlMemRead]) && w_ex_match) ||
                   w_exm_match;
  end
`endif

  // ALU operand selection and registered control outputs.
  always_comb begin
    bus.alu_in1       = r_src1 ? {{(DATA_W-5){1'b0}}, r_shamt} : w_rs_fwd;
    bus.alu_in2       = r_src2 ? r_ext_imm : w_rt_fwd;
    bus.ex_store_data = w_rt_fwd;
    bus.alu_ctrl      = r_alu_ctrl;
    bus.alu_sign      = r_sign;
    bus.ex_dst        = r_dst;
    bus.ex_ctrl       = r_ctrl;
    bus.ex_valid      = r_valid;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by randomized traffic,
// all compared against an instruction-level reference model of the EX slot.
module tb_id_ex_stage;

  logic clk;
  logic reset;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the instruction currently held in EX, as decoded fields.
  logic        m_valid;
  logic [3:0]  m_ctrl;
  logic [3:0]  m_op;
  logic        m_sign;
  logic        m_src1;
  logic        m_src2;
  logic        m_ext;
  logic [4:0]  m_rs;
  logic [4:0]  m_rt;
  logic [4:0]  m_dst;
  logic [31:0] m_rs_data;
  logic [31:0] m_rt_data;
  logic [15:0] m_imm;
  logic [4:0]  m_shamt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_ctrl = 0; m_op = 0; m_sign = 0; m_src1 = 0; m_src2 = 0; m_ext = 0;
    m_rs = 0; m_rt = 0; m_dst = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_shamt = 0;
  endtask

  // Called right at the rising edge with inputs still stable.
  task automatic model_edge();
    if (bus.flush) begin
      model_clear();
    end else if (!bus.stall) begin
      m_valid = bus.id_valid;  m_ctrl = bus.id_ctrl;  m_op = bus.id_alu_ctrl;
      m_sign = bus.id_sign;  m_src1 = bus.id_alu_src1;  m_src2 = bus.id_alu_src2;
      m_ext = bus.id_ext_op;  m_rs = bus.id_rs_addr;  m_rt = bus.id_rt_addr;
      m_dst = bus.id_dst;  m_rs_data = bus.id_rs_data;  m_rt_data = bus.id_rt_data;
      m_imm = bus.id_imm;  m_shamt = bus.id_shamt;
    end
  endtask

  // Value of a source register as the EX instruction should see it.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
`ifdef ID_EX_FORWARD_EN
    if (r == 0) return rf;
    if (bus.exm_regwrite && bus.exm_dst == r) return bus.exm_data;
    if (bus.mwb_regwrite && bus.mwb_dst == r) return bus.mwb_data;
`endif
    return rf;
  endfunction

  function automatic logic exp_load_use();
    logic [4:0] producers[$];
`ifdef ID_EX_FORWARD_EN
    if (m_valid && m_ctrl[2]) producers.push_back(m_dst);
`else
    if (m_valid && (m_ctrl[3] || m_ctrl[2])) producers.push_back(m_dst);
    if (bus.exm_regwrite) producers.push_back(bus.exm_dst);
`endif
    foreach (producers[i]) begin
      if (producers[i] != 0 &&
          (producers[i] == bus.id_rs_addr || producers[i] == bus.id_rt_addr)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] imm_x;
    imm_x = m_ext ? 32'($signed(m_imm)) : {16'h0, m_imm};
    check({tag, ".valid"}, 32'(bus.ex_valid), 32'(m_valid));
    check({tag, ".ctrl"},  32'(bus.ex_ctrl),  32'(m_ctrl));
    check({tag, ".op"},    32'(bus.alu_ctrl), 32'(m_op));
    check({tag, ".sign"},  32'(bus.alu_sign), 32'(m_sign));
    check({tag, ".dst"},   32'(bus.ex_dst),   32'(m_dst));
    check({tag, ".in1"},   bus.alu_in1, m_src1 ? 32'(m_shamt) : operand(m_rs, m_rs_data));
    check({tag, ".in2"},   bus.alu_in2, m_src2 ? imm_x : operand(m_rt, m_rt_data));
    check({tag, ".st"},    bus.ex_store_data, operand(m_rt, m_rt_data));
    check({tag, ".lu"},    32'(bus.load_use), 32'(exp_load_use()));
  endtask

  task automatic drive_idle();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0; bus.id_alu_ctrl = 0; bus.id_sign = 0;
    bus.id_alu_src1 = 0; bus.id_alu_src2 = 0; bus.id_ext_op = 0; bus.id_ctrl = 0;
    bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_dst = 0; bus.id_rs_data = 0;
    bus.id_rt_data = 0; bus.id_imm = 0; bus.id_shamt = 0;
    bus.exm_regwrite = 0; bus.exm_dst = 0; bus.exm_data = 0;
    bus.mwb_regwrite = 0; bus.mwb_dst = 0; bus.mwb_data = 0;
  endtask

  task automatic clock_in();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    drive_idle();
    model_clear();
    reset = 0;
    #3;
    check_all("reset");
    check("reset.in1", bus.alu_in1, 32'h0);
    @(negedge clk);
    reset = 1;

    // Reset mid-operation, asynchronously between edges
    bus.id_valid = 1; bus.id_ctrl = 4'b1000; bus.id_rs_addr = 1; bus.id_rt_addr = 2;
    bus.id_rs_data = 32'h11; bus.id_rt_data = 32'h22; bus.id_dst = 3;
    clock_in();
    check("load.valid", 32'(bus.ex_valid), 32'h1);
    check("load.in1", bus.alu_in1, 32'h11);
    check("load.in2", bus.alu_in2, 32'h22);
    #2;
    reset = 0;
    model_clear();
    #1;
    check("arst.valid", 32'(bus.ex_valid), 32'h0);
    check("arst.ctrl", 32'(bus.ex_ctrl), 32'h0);
    check("arst.in1", bus.alu_in1, 32'h0);
    check("arst.in2", bus.alu_in2, 32'h0);
    #1;
    reset = 1;
    drive_idle();

    // Immediate extension and shamt
    bus.id_valid = 1; bus.id_ext_op = 1; bus.id_imm = 16'h8000; bus.id_alu_src2 = 1;
    clock_in();
    check("imm.sext", bus.alu_in2, 32'hFFFF8000);
    bus.id_ext_op = 0;
    clock_in();
    check("imm.zext", bus.alu_in2, 32'h00008000);
    bus.id_alu_src1 = 1; bus.id_shamt = 5'd31; bus.id_alu_ctrl = 4'd6;
    clock_in();
    check("shamt.in1", bus.alu_in1, 32'd31);
    check("shamt.op", 32'(bus.alu_ctrl), 32'd6);
    check_all("shamt");
    drive_idle();

    // Forwarding priority
    bus.id_valid = 1; bus.id_rs_addr = 5; bus.id_rs_data = 32'h0BAD;
    clock_in();
    bus.exm_regwrite = 1; bus.exm_dst = 5; bus.exm_data = 32'hAAAA0000;
    bus.mwb_regwrite = 1; bus.mwb_dst = 5; bus.mwb_data = 32'h5555;
    #1;
`ifdef ID_EX_FORWARD_EN
    check("fwd.exm", bus.alu_in1, 32'hAAAA0000);
`else
    check("fwd.exm", bus.alu_in1, 32'h0BAD);
`endif
    bus.exm_regwrite = 0;
    #1;
`ifdef ID_EX_FORWARD_EN
    check("fwd.mwb", bus.alu_in1, 32'h5555);
`else
    check("fwd.mwb", bus.alu_in1, 32'h0BAD);
`endif
    check_all("fwd");
    bus.id_rs_addr = 0; bus.id_rs_data = 32'h77; bus.exm_regwrite = 1; bus.exm_dst = 0;
    bus.mwb_dst = 0;
    clock_in();
    check("fwd.zero", bus.alu_in1, 32'h77);
    drive_idle();

    // Load-use then flush
    bus.id_valid = 1; bus.id_ctrl = 4'b1101; bus.id_dst = 8; bus.id_alu_ctrl = 4'd2;
    clock_in();
    bus.id_ctrl = 0; bus.id_rs_addr = 3; bus.id_rt_addr = 8;
    #1;
    check("lu.flag", 32'(bus.load_use), 32'h1);
    bus.flush = 1;
    clock_in();
    check("lu.valid", 32'(bus.ex_valid), 32'h0);
    check("lu.ctrl", 32'(bus.ex_ctrl), 32'h0);
    check("lu.op", 32'(bus.alu_ctrl), 32'h0);
    check_all("lu");
    drive_idle();

    // Stall holds for three cycles, then flush wins over stall
    bus.id_valid = 1; bus.id_alu_ctrl = 4'd3; bus.id_rs_addr = 4; bus.id_rs_data = 32'h1111;
    bus.id_ctrl = 4'b1000; bus.id_dst = 6;
    clock_in();
    bus.stall = 1; bus.id_alu_ctrl = 4'd9; bus.id_rs_data = 32'h2222; bus.id_dst = 7;
    for (int i = 0; i < 3; i++) begin
      clock_in();
      check("stall.op", 32'(bus.alu_ctrl), 32'd3);
      check("stall.in1", bus.alu_in1, 32'h1111);
      check("stall.dst", 32'(bus.ex_dst), 32'd6);
    end
    bus.flush = 1;
    clock_in();
    check("sf.valid", 32'(bus.ex_valid), 32'h0);
    check("sf.in1", bus.alu_in1, 32'h0);
    check("sf.dst", 32'(bus.ex_dst), 32'h0);
    drive_idle();

    // Store data via rt while in2 takes the immediate
    bus.id_valid = 1; bus.id_ctrl = 4'b0010; bus.id_rt_addr = 9; bus.id_rt_data = 32'h9999;
    bus.id_alu_src2 = 1; bus.id_ext_op = 1; bus.id_imm = 16'h0010;
    clock_in();
    bus.mwb_regwrite = 1; bus.mwb_dst = 9; bus.mwb_data = 32'h1234;
    #1;
`ifdef ID_EX_FORWARD_EN
    check("store.data", bus.ex_store_data, 32'h1234);
`else
    check("store.data", bus.ex_store_data, 32'h9999);
`endif
    check("store.in2", bus.alu_in2, 32'h10);
    drive_idle();

    // Randomized traffic with small register numbers to provoke hazards
    for (int n = 0; n < 400; n++) begin
      bus.stall = ($urandom_range(0, 9) < 2);
      bus.flush = ($urandom_range(0, 9) < 1);
      bus.id_valid = 1'($urandom); bus.id_alu_ctrl = 4'($urandom_range(0, 10));
      bus.id_sign = 1'($urandom); bus.id_alu_src1 = 1'($urandom);
      bus.id_alu_src2 = 1'($urandom); bus.id_ext_op = 1'($urandom);
      bus.id_ctrl = 4'($urandom); bus.id_rs_addr = 5'($urandom_range(0, 7));
      bus.id_rt_addr = 5'($urandom_range(0, 7)); bus.id_dst = 5'($urandom_range(0, 7));
      bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = 16'($urandom);
      bus.id_shamt = 5'($urandom);
      bus.exm_regwrite = 1'($urandom); bus.exm_dst = 5'($urandom_range(0, 7));
      bus.exm_data = $urandom;
      bus.mwb_regwrite = 1'($urandom); bus.mwb_dst = 5'($urandom_range(0, 7));
      bus.mwb_data = $urandom;
      #1;
      check_all("rand");
      clock_in();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with operand forwarding and operand selection for the execute stage.
- Captures decoded control and register data each cycle.
- Drives the ALU inputs directly: opcode, sign flag, in1 and in2.
- Resolves RAW hazards from EX/MEM and MEM/WB, and flags load-use hazards back to the decode/hazard unit.

Parameters:
DATA_W, 32, datapath width (in1/in2/result)
REG_AW, 5, register address width

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset)
stall  input  1  hold stage contents (downstream also frozen)
flush  input  1  load a bubble
id_valid  input  1  decode slot holds a real instruction
id_alu_ctrl  input  4  ALU opcode (0 ADD … 10 GT)
id_sign  input  1  signed compare/arith-shift select
id_alu_src1  input  1  1: in1 = zero-extended shamt, 0: rs
id_alu_src2  input  1  1: in2 = extended imm, 0: rt
id_ext_op  input  1  1: sign-extend imm, 0: zero-extend
id_ctrl  input  4  {RegWrite, MemRead, MemWrite, MemtoReg}
id_rs_addr / id_rt_addr / id_dst  input  REG_AW each  source/dest regs
id_rs_data / id_rt_data  input  DATA_W each  register file read data
id_imm  input  16  immediate field
id_shamt  input  5  shift amount field
exm_regwrite, exm_dst, exm_data  input  1/REG_AW/DATA_W  EX/MEM writeback source
mwb_regwrite, mwb_dst, mwb_data  input  1/REG_AW/DATA_W  MEM/WB writeback source
alu_ctrl  output  4  to ALU
alu_sign  output  1  to ALU
alu_in1 / alu_in2  output  DATA_W each  to ALU
ex_store_data  output  DATA_W  forwarded rt for stores
ex_dst  output  REG_AW  destination register
ex_ctrl  output  4  registered {RegWrite, MemRead, MemWrite, MemtoReg}
ex_valid  output  1  EX slot holds a real instruction
load_use  output  1  combinational load-use hazard flag to decode

Behaviour:
- Reset (reset = 0, asynchronous): all registers clear.
  - ex_valid = 0, ex_ctrl = 0, alu_ctrl = 0, alu_sign = 0, ex_dst = 0.
  - Stored data and imm are 0, so alu_in1, alu_in2 and ex_store_data read 0.
  - Release is synchronous to clk.
- Per rising edge, priority order:
  - flush: load bubble (valid = 0, ctrl = 0, alu_ctrl = ADD, sign = 0, dst = 0, data = 0).
  - else stall: hold all registers.
  - else capture all id_* inputs.
- flush and stall asserted together: flush wins.
- Latency: one cycle from ID to the ALU inputs. The ALU is combinational, so the result is valid in the same EX cycle.
- Immediate extension: performed at capture.
  - ext_op = 1: {16{imm[15]}, imm}.
  - ext_op = 0: {16'b0, imm}.
- Forwarding (combinational, from registered addresses):
  - Applies separately to rs_fwd and rt_fwd.
  - Source is EX/MEM if exm_regwrite && exm_dst == src && src != 0.
  - Else MEM/WB if mwb_regwrite && mwb_dst == src && src != 0.
  - Else the registered data.
  - EX/MEM has priority over MEM/WB. $0 is never forwarded.
- Operand selection:
  - alu_in1 = alu_src1 ? {27'b0, shamt} : rs_fwd.
  - alu_in2 = alu_src2 ? ext_imm : rt_fwd.
  - ex_store_data = rt_fwd always.
- Bubble slot: alu_in1 = alu_in2 = 0 and ALU opcode is ADD; the ALU output is then 0 and harmless.
- load_use = ex_valid && ex_ctrl.MemRead && ex_dst != 0 && (ex_dst == id_rs_addr || ex_dst == id_rt_addr).
  - The decode/hazard unit responds by stalling IF/ID and asserting flush here next edge.
  - The flag is not masked by id_valid; decode qualifies it.
- Stall semantics: while stall = 1, forwarding sources must also be frozen upstream. Outputs remain stable and identical cycle to cycle.

Optional Feature:
Macro: ID_EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - rs_fwd and rt_fwd equal the registered data; exm_* and mwb_* are unused.
  - load_use widens to a full RAW flag: asserts when ex_valid && RegWrite matches rs/rt (non-zero).
  - It also asserts when exm_regwrite && exm_dst matches rs/rt (non-zero).

Test Plan:
- Reset mid-operation: load valid ADD instruction, assert reset = 0 asynchronously between edges -> ex_valid, ex_ctrl, alu_in1, alu_in2 go to 0 immediately without a clock.
- Immediate/shamt: ext_op = 1, imm = 16'h8000, alu_src2 = 1 -> alu_in2 = 32'hFFFF8000; ext_op = 0 -> 32'h00008000; alu_src1 = 1, shamt = 5'd31, alu_ctrl = SL -> alu_in1 = 31.
- Forward priority: rs = 5, exm {1, 5, 32'hAAAA0000} and mwb {1, 5, 32'h5555} -> alu_in1 = 32'hAAAA0000; drop exm_regwrite -> 32'h5555; rs = 0 with exm_dst = 0 -> registered rs_data.
- Load-use: EX holds lw dst = 8, ID rt_addr = 8 -> load_use = 1; next edge flush = 1 -> ex_valid = 0, ex_ctrl = 0, alu_ctrl = 0.
- Stall vs flush: stall = 1 for 3 cycles -> outputs unchanged; stall = 1 and flush = 1 same edge -> bubble loaded.
- Store data: MemWrite, rt = 9, mwb forwarding 32'h1234 to reg 9, alu_src2 = 1 -> ex_store_data = 32'h1234, alu_in2 = ext imm.
